exe_mem_stage: RTL

- EX/MEM pipeline register for the interrupt-capable pipelined CPU.
- Sits directly downstream of the ALU. It captures ealu and IntOverflow together with the EX-stage control bits.
- Converts a signed-arithmetic overflow into a precise exception request to CP0. The faulting instruction's register/memory write is squashed, and the pipeline is held flushed until CP0 acknowledges.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/exc_capture.sv | 78 +++++++
 rtl/exe_mem_stage.sv | 86 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU: exception FSM encoding, CP0 cause
// codes and the default datapath width.
package cpu_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic {
    RUN      = 1'b0,
    EXC_WAIT = 1'b1
  } exc_state_t;

  localparam logic [4:0] CAUSE_OV  = 5'd12;
  localparam logic [4:0] CAUSE_INT = 5'd0;

endpackage

// File: rtl/exc_capture.sv
// Overflow exception capture: the RUN/EXC_WAIT FSM plus the registers that
// present a pending exception to CP0 until it is acknowledged.
module exc_capture
  import cpu_pkg::*;
#(
  parameter int         DATA_W     = DATA_W_DEFAULT,
  parameter logic [4:0] CAUSE_CODE = CAUSE_OV
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              stall,
  input  logic              ovf,
  input  logic              ebd,
  input  logic [DATA_W-1:0] epc,
  input  logic              exc_ack,
  output logic              exc_req,
  output logic [4:0]        exc_cause,
  output logic [DATA_W-1:0] exc_epc,
  output logic              exc_bd,
  output logic              flush_out
);

  exc_state_t        state_reg, state_next;
  logic              req_reg, req_next;
  logic [4:0]        cause_reg, cause_next;
  logic [DATA_W-1:0] epc_reg, epc_next;
  logic              bd_reg, bd_next;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= RUN;
      req_reg   <= 1'b0;
      cause_reg <= '0;
      epc_reg   <= '0;
      bd_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      cause_reg <= cause_next;
      epc_reg   <= epc_next;
      bd_reg    <= bd_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    cause_next = cause_reg;
    epc_next   = epc_reg;
    bd_next    = bd_reg;
    case (state_reg)
      RUN: begin
        if (!stall && ovf) begin
          state_next = EXC_WAIT;
          req_next   = 1'b1;
          cause_next = CAUSE_CODE;
          bd_next    = ebd;
          // A delay-slot fault restarts at the branch, one word earlier.
          epc_next   = ebd ? (epc - DATA_W'(4)) : epc;
        end
      end
      EXC_WAIT: begin
        if (exc_ack) begin
          state_next = RUN;
          req_next   = 1'b0;
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign exc_req   = req_reg;
  assign exc_cause = cause_reg;
  assign exc_epc   = epc_reg;
  assign exc_bd    = bd_reg;
  assign flush_out = (state_reg == EXC_WAIT);

endmodule

// File: rtl/exe_mem_stage.sv
// EX/MEM pipeline register with precise signed-overflow exception: the
// faulting instruction is squashed and the front end is flushed until CP0 acks.
module exe_mem_stage #(
  parameter int         DATA_W   = cpu_pkg::DATA_W_DEFAULT,
  parameter logic [4:0] CAUSE_OV = cpu_pkg::CAUSE_OV
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ealu,
  input  logic              IntOverflow,
  input  logic              eovf_en,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic              ewmem,
  input  logic [4:0]        ern,
  input  logic [DATA_W-1:0] eb,
  input  logic [DATA_W-1:0] epc,
  input  logic              ebd,
  input  logic              exc_ack,
  output logic              mvalid,
  output logic              mwreg,
  output logic              mm2reg,
  output logic              mwmem,
  output logic [4:0]        mrn,
  output logic [DATA_W-1:0] malu,
  output logic [DATA_W-1:0] mb,
  output logic              exc_req,
  output logic [4:0]        exc_cause,
  output logic [DATA_W-1:0] exc_epc,
  output logic              exc_bd,
  output logic              flush_out
);

  logic ovf;
  logic commit;

  // Unsigned ops and bubbles never trap.
  assign ovf    = ex_valid & eovf_en & IntOverflow;
  assign commit = ex_valid & ~ovf;

  exc_capture #(
    .DATA_W    (DATA_W),
    .CAUSE_CODE(CAUSE_OV)
  ) u_exc_capture (
    .clock    (clock),
    .resetn   (resetn),
    .stall    (stall),
    .ovf      (ovf),
    .ebd      (ebd),
    .epc      (epc),
    .exc_ack  (exc_ack),
    .exc_req  (exc_req),
    .exc_cause(exc_cause),
    .exc_epc  (exc_epc),
    .exc_bd   (exc_bd),
    .flush_out(flush_out)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mvalid <= 1'b0;
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
      mrn    <= '0;
      malu   <= '0;
      mb     <= '0;
    end else if (flush_out) begin
      // Waiting on CP0: keep issuing bubbles, ignore whatever EX holds.
      mvalid <= 1'b0;
      mwreg  <= 1'b0;
      mwmem  <= 1'b0;
    end else if (!stall) begin
      mvalid <= commit;
      mwreg  <= ewreg & commit;
      mwmem  <= ewmem & commit;
      mm2reg <= em2reg;
      mrn    <= ern;
      malu   <= ealu;
      mb     <= eb;
    end
  end

endmodule
